// File: rtl/lcd_stream_driver.sv
// HD44780-class character-LCD write engine: command FIFO, bus timing, memory-window refresh.
// Optional LCD_BUS4_EN: 4-bit bus, each byte sent as high then low nibble on o_data[7:4].
module lcd_stream_driver #(
  parameter int WIDTH_MEM    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYC    = 3,
  parameter int E_HIGH_CYC   = 25,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 80000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_rs,
  input  logic [7:0]           i_byte,
  input  logic                 i_refresh,
  input  logic [WIDTH_MEM-1:0] i_addr_begin,
  input  logic [WIDTH_MEM-1:0] i_addr_end,
  input  logic [6:0]           i_ddram_base,
  output logic [WIDTH_MEM-1:0] o_addr,
  input  logic [7:0]           i_mem_data,
  output logic [7:0]           o_data,
  output logic                 o_RS,
  output logic                 o_RW,
  output logic                 o_E,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

`ifdef LCD_BUS4_EN
  localparam logic BUS4 = 1'b1;
`else
  localparam logic BUS4 = 1'b0;
`endif

  localparam int MAX_AB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_CD  = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAX_EF  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_EF > CLR_WAIT_CYC) ? MAX_EF : CLR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SETUP = 3'd3,
    ST_PULSE = 3'd4,
    ST_HOLD  = 3'd5,
    ST_WAIT  = 3'd6
  } state_t;

  function automatic logic [7:0] bus_val(input logic [7:0] b, input logic lo);
    logic [7:0] v;
    if (!BUS4) v = b;
    else if (lo) v = {b[3:0], 4'h0};
    else v = {b[7:4], 4'h0};
    return v;
  endfunction

  function automatic logic is_clr(input logic rs, input logic [7:0] b);
    return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
  endfunction

  logic [8:0]           fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]       count_r, count_s;
  logic                 push_s, pop_s;
  logic [8:0]           head_s;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 cnt_zero_s;
  logic [7:0]           cur_byte_r, cur_byte_s, data_s, load_byte_s;
  logic                 nib_lo_r, nib_lo_s, rs_s, e_s, done_s, ovf_s, load_s, load_rs_s;
  logic                 pend_r, pend_s, run_r, run_s;
  logic [WIDTH_MEM-1:0] beg_r, beg_s, end_r, end_s, acnt_r, acnt_s, addr_s;
  logic [6:0]           base_r, base_s;

  assign push_s     = i_valid & o_ready;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // FIFO occupancy after this edge
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + 1'b1;
      2'b01:   count_s = count_r - 1'b1;
      default: count_s = count_r;
    endcase
  end

  // Command FIFO storage, pointers and registered ready
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
      o_ready  <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {i_rs, i_byte};
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_s;
      o_ready <= (count_s != FULL_CNT);
    end
  end

  // Next-state and next-output logic for the write engine
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    data_s      = o_data;
    rs_s        = o_RS;
    e_s         = o_E;
    addr_s      = o_addr;
    done_s      = 1'b0;
    ovf_s       = 1'b0;
    cur_byte_s  = cur_byte_r;
    nib_lo_s    = nib_lo_r;
    pend_s      = pend_r;
    run_s       = run_r;
    beg_s       = beg_r;
    end_s       = end_r;
    base_s      = base_r;
    acnt_s      = acnt_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    load_rs_s   = 1'b0;
    load_byte_s = 8'h00;

    // A new request is only considered when nothing is pending or running
    if (i_refresh && !pend_r && !run_r) begin
      if (i_addr_end < i_addr_begin) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = 1'b1;
        beg_s  = i_addr_begin;
        end_s  = i_addr_end;
        base_s = i_ddram_base;
      end
    end else begin
      ovf_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (count_r != {(PTR_W + 1){1'b0}}) begin
          pop_s       = 1'b1;
          load_s      = 1'b1;
          load_rs_s   = head_s[8];
          load_byte_s = head_s[7:0];
        end else if (pend_r) begin
          pend_s      = 1'b0;
          run_s       = 1'b1;
          acnt_s      = beg_r;
          load_s      = 1'b1;
          load_rs_s   = 1'b0;
          load_byte_s = {1'b1, base_r};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_s = ST_FETCH;
      ST_FETCH: begin
        load_s      = 1'b1;
        load_rs_s   = 1'b1;
        load_byte_s = i_mem_data;
      end
      ST_SETUP: begin
        if (cnt_zero_s) begin
          state_s = ST_PULSE;
          cnt_s   = LD_EHIGH;
          e_s     = 1'b1;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          state_s = ST_HOLD;
          cnt_s   = LD_HOLD;
          e_s     = 1'b0;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero_s) begin
          cnt_s = cnt_r - 1'b1;
        end else if (BUS4 && !nib_lo_r) begin
          state_s  = ST_SETUP;
          cnt_s    = LD_SETUP;
          nib_lo_s = 1'b1;
          data_s   = bus_val(cur_byte_r, 1'b1);
        end else begin
          state_s = ST_WAIT;
          cnt_s   = is_clr(o_RS, cur_byte_r) ? LD_CLR : LD_WAIT;
        end
      end
      ST_WAIT: begin
        // During a refresh, RS=0 marks the set-address command still on the bus
        if (!cnt_zero_s) begin
          cnt_s = cnt_r - 1'b1;
        end else if (!run_r) begin
          state_s = ST_IDLE;
        end else if (!o_RS) begin
          state_s = ST_LOAD;
          addr_s  = acnt_r;
        end else if (acnt_r == end_r) begin
          state_s = ST_IDLE;
          run_s   = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_LOAD;
          acnt_s  = acnt_r + 1'b1;
          addr_s  = acnt_r + 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        e_s     = 1'b0;
      end
    endcase

    if (load_s) begin
      state_s    = ST_SETUP;
      cnt_s      = LD_SETUP;
      rs_s       = load_rs_s;
      cur_byte_s = load_byte_s;
      data_s     = bus_val(load_byte_s, 1'b0);
      nib_lo_s   = 1'b0;
    end else begin
      cur_byte_s = cur_byte_s;
    end
  end

  // State, counters and all registered LCD-side outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      cur_byte_r <= 8'h00;
      nib_lo_r   <= 1'b0;
      pend_r     <= 1'b0;
      run_r      <= 1'b0;
      beg_r      <= {WIDTH_MEM{1'b0}};
      end_r      <= {WIDTH_MEM{1'b0}};
      acnt_r     <= {WIDTH_MEM{1'b0}};
      base_r     <= 7'h00;
      o_addr     <= {WIDTH_MEM{1'b0}};
      o_data     <= 8'h00;
      o_RS       <= 1'b0;
      o_RW       <= 1'b0;
      o_E        <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_byte_r <= cur_byte_s;
      nib_lo_r   <= nib_lo_s;
      pend_r     <= pend_s;
      run_r      <= run_s;
      beg_r      <= beg_s;
      end_r      <= end_s;
      acnt_r     <= acnt_s;
      base_r     <= base_s;
      o_addr     <= addr_s;
      o_data     <= data_s;
      o_RS       <= rs_s;
      o_RW       <= 1'b0;
      o_E        <= e_s;
      o_busy     <= (state_s != ST_IDLE);
      o_done     <= done_s;
      o_overflow <= ovf_s;
    end
  end

endmodule

// File: tb/tb_lcd_stream_driver.sv
// Scoreboard bench for lcd_stream_driver: expected bus strobes are queued at stimulus time
// and a negedge monitor pops and compares them on every rising edge of o_E.
`timescale 1ns/1ps
module tb_lcd_stream_driver;
  localparam int WM = 4, DEPTH = 4, SET = 1, EH = 4, HLD = 1, WT = 10, CWT = 50;
`ifdef LCD_BUS4_EN
  localparam int NIB = 2;
`else
  localparam int NIB = 1;
`endif

  logic          clk = 1'b0, rst = 1'b1, valid = 1'b0, rs_in = 1'b0, refresh = 1'b0;
  logic [7:0]    byte_in = 8'h00, mem_data = 8'h00;
  logic [WM-1:0] addr_begin = '0, addr_end = '0, addr;
  logic [6:0]    ddram_base = 7'h00;
  logic          ready, lcd_rs, lcd_rw, lcd_e, busy, done, overflow;
  logic [7:0]    data;

  logic [7:0]    mem [16];
  int            checks = 0, errors = 0, cyc = 0, acc_cyc = 0, busy_fall = 0;
  int            done_cnt = 0, ovf_cnt = 0, busy_seen = 0;
  logic [8:0]    exp_q [$];
  int            rise_q [$], fall_q [$];
  logic [WM-1:0] addr_log [$];
  logic          e_prev = 1'b0, busy_prev = 1'b0, abort_flag = 1'b0;
  logic [8:0]    rise_word = 9'h000;

  lcd_stream_driver #(
    .WIDTH_MEM(WM), .FIFO_DEPTH(DEPTH), .SETUP_CYC(SET), .E_HIGH_CYC(EH),
    .HOLD_CYC(HLD), .WAIT_CYC(WT), .CLR_WAIT_CYC(CWT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_rs(rs_in), .i_byte(byte_in),
    .i_refresh(refresh), .i_addr_begin(addr_begin), .i_addr_end(addr_end), .i_ddram_base(ddram_base),
    .o_addr(addr), .i_mem_data(mem_data), .o_data(data), .o_RS(lcd_rs), .o_RW(lcd_rw), .o_E(lcd_e),
    .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1000;
  endfunction

  // Reference model: one strobe per byte, or two nibble strobes on a 4-bit bus
  task automatic expect_byte(input logic r, input logic [7:0] b);
    if (NIB == 2) begin
      exp_q.push_back({r, b[7:4], 4'h0});
      exp_q.push_back({r, b[3:0], 4'h0});
    end else begin
      exp_q.push_back({r, b});
    end
  endtask

  // Monitor: compare every strobe against the scoreboard, check width and stability
  always @(negedge clk) begin
    if (lcd_e === 1'b1 && e_prev === 1'b0) begin
      rise_q.push_back(cyc);
      addr_log.push_back(addr);
      rise_word = {lcd_rs, data};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_e: got word 0x%0h expected no strobe", {lcd_rs, data});
      end else begin
        check("e_word", {lcd_rs, data}, exp_q.pop_front());
      end
    end
    if (lcd_e === 1'b0 && e_prev === 1'b1) begin
      fall_q.push_back(cyc);
      if (!abort_flag) begin
        check("e_width", cyc - q_at(rise_q, rise_q.size() - 1), EH);
        check("e_stable", {lcd_rs, data}, rise_word);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
    if (busy === 1'b1) busy_seen++;
    if (busy === 1'b0 && busy_prev === 1'b1) busy_fall = cyc;
    e_prev = lcd_e;
    busy_prev = busy;
  end

  task automatic clear_logs();
    rise_q.delete(); fall_q.delete(); addr_log.delete();
  endtask

  task automatic push(input logic r, input logic [7:0] b);
    int guard = 0;
    valid = 1'b1; rs_in = r; byte_in = b;
    while (ready !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout: ready=%b expected 1", ready);
    end
    @(posedge clk);
    expect_byte(r, b);
    @(negedge clk);
    acc_cyc = cyc;
    valid = 1'b0;
  endtask

  task automatic do_refresh(input logic [WM-1:0] b, input logic [WM-1:0] e, input logic [6:0] base,
                            input bit model);
    refresh = 1'b1; addr_begin = b; addr_end = e; ddram_base = base;
    @(posedge clk);
    if (model && e >= b) begin
      expect_byte(1'b0, {1'b1, base});
      for (int a = b; a <= e; a++) expect_byte(1'b1, mem[a]);
    end
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    repeat (3) @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && guard < 5000) begin @(negedge clk); guard++; end
    check("idle_reached", guard < 5000, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  int         d0, o0, b0, n0, guard;
  logic [3:0] rb, re;
  logic [7:0] bv;

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);     check("rst_addr", addr, 0);
    check("rst_rs", lcd_rs, 0);     check("rst_rw", lcd_rw, 0);
    check("rst_e", lcd_e, 0);       check("rst_busy", busy, 0);
    check("rst_done", done, 0);     check("rst_ovf", overflow, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single data word: latency, pulse and busy window
    clear_logs();
    push(1'b1, 8'h41);
    wait_idle();
    check("t1_rises", rise_q.size(), NIB);
    check("t1_rise_lat", q_at(rise_q, 0) - acc_cyc, 1 + SET);
    check("t1_busy_low", busy_fall - acc_cyc, 1 + NIB * (SET + EH + HLD) + WT);
    check("t1_rw", lcd_rw, 0);

    // Clear command uses the long wait
    clear_logs();
    push(1'b0, 8'h01);
    push(1'b1, 8'h42);
    wait_idle();
    check("t2_clr_gap", q_at(rise_q, NIB) - q_at(fall_q, NIB - 1), HLD + CWT + 1 + SET);

    // Back-to-back burst fills the FIFO
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      bv = 8'($urandom);
      push(1'b1, bv);
      if (i == 3) check("t3_ready_3q", ready, 1);
      if (i == 4) check("t3_ready_full", ready, 0);
    end
    wait_idle();
    check("t3_rises", rise_q.size(), 6 * NIB);
    for (int i = 1; i < 6; i++)
      check("t3_gap", q_at(rise_q, i * NIB) - q_at(fall_q, i * NIB - 1), HLD + WT + 1 + SET);

    // Directed refresh window
    for (int a = 0; a < 16; a++) mem[a] = 8'(8'h30 + a);
    clear_logs();
    d0 = done_cnt;
    do_refresh(4'd2, 4'd5, 7'h40, 1'b1);
    wait_idle();
    check("t4_done", done_cnt - d0, 1);
    check("t4_rises", rise_q.size(), 5 * NIB);
    for (int k = 0; k < 4; k++)
      if (addr_log.size() > (k + 1) * NIB) check("t4_addr", addr_log[(k + 1) * NIB], 2 + k);

    // Rejected refresh
    clear_logs();
    o0 = ovf_cnt; b0 = busy_seen;
    do_refresh(4'd3, 4'd1, 7'h10, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_ovf", ovf_cnt - o0, 1);
    check("t5_no_e", rise_q.size(), 0);
    check("t5_busy", busy_seen - b0, 0);

    // Random refreshes, a second request while running, words queued during refresh
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(rb, 15));
      if (it == 4) begin rb = 4'd13; re = 4'd15; end
      d0 = done_cnt; o0 = ovf_cnt;
      do_refresh(rb, re, 7'($urandom), 1'b1);
      repeat (3) @(negedge clk);
      do_refresh(4'($urandom), 4'($urandom), 7'($urandom), 1'b0);
      push(1'($urandom), 8'($urandom));
      wait_idle();
      check("t6_done", done_cnt - d0, 1);
      check("t6_ovf", ovf_cnt - o0, 0);
    end

    // Random command/data words with random spacing
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      bv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      push(1'($urandom), bv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check("t7_rises", rise_q.size(), 16 * NIB);

    // Reset while E is high
    clear_logs();
    push(1'b1, 8'h41);
    guard = 0;
    while (lcd_e !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    check("t8_e_seen", lcd_e, 1);
    abort_flag = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t8_e_low", lcd_e, 0);
    check("t8_ready", ready, 1);
    check("t8_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    n0 = rise_q.size();
    repeat (40) @(negedge clk);
    check("t8_no_resume", rise_q.size(), n0);
    abort_flag = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
